// File: rtl/credito_acumulador.sv
// Coin credit accumulator for the vending path.
// Adds credit from up to three debounced coin inputs. Raises hay_credito once
// the credit reaches PRICE, and runs a one-cycle sale or cancel that reports
// the change to return. A coin that cannot be accepted gets a one-cycle
// rejection pulse.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ACUM       | accumulating coins, waiting for buy or cancel
//   VENTA      | one-cycle sale: dispensa, cambio = credito - PRICE
//   DEVOLUCION | one-cycle cancel: cambio = credito, nothing dispensed
module credito_acumulador #(
  parameter int WIDTH = 5,
  parameter int PRICE = 20,
  parameter int COIN0 = 1,
  parameter int COIN1 = 5,
  parameter int COIN2 = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       coin_in,
  input  logic             buy,
  input  logic             cancel,
  output logic [WIDTH-1:0] credito,
  output logic             hay_credito,
  output logic             dispensa,
  output logic [WIDTH-1:0] cambio,
  output logic             cambio_valid,
  output logic             moneda_rechazada
);

  typedef enum logic [1:0] {
    ACUM       = 2'd0,
    VENTA      = 2'd1,
    DEVOLUCION = 2'd2
  } state_t;

  // Two guard bits keep the sum of three simultaneous coins plus the
  // current credit from wrapping before the overflow compare.
  typedef logic [WIDTH+1:0] ext_t;
  typedef logic [WIDTH-1:0] cred_t;

  localparam cred_t PRICE_W = cred_t'(PRICE);
  localparam ext_t  MAX_X   = ext_t'((1 << WIDTH) - 1);
  localparam ext_t  COIN0_X = ext_t'(COIN0);
  localparam ext_t  COIN1_X = ext_t'(COIN1);
  localparam ext_t  COIN2_X = ext_t'(COIN2);

  state_t     state_q, state_d;
  cred_t      credito_q, credito_d;
  logic [2:0] coin_q;
  logic       rech_q, rech_d;

  logic [2:0] ev;
  logic       ev_any;
  ext_t       add;
  ext_t       sum_x;
  logic       cabe;
  logic       hay;

  // Rising-edge detect on the coin levels and the value they add together.
  always_comb begin
    ev     = coin_in & ~coin_q;
    ev_any = |ev;
    add    = '0;
    if (ev[0]) add = add + COIN0_X;
    if (ev[1]) add = add + COIN1_X;
    if (ev[2]) add = add + COIN2_X;
    sum_x  = {2'b00, credito_q} + add;
    cabe   = (sum_x <= MAX_X);
    hay    = (credito_q >= PRICE_W);
  end

  // Next state, next credit and coin rejection; cancel beats buy beats coin.
  always_comb begin
    state_d   = state_q;
    credito_d = credito_q;
    rech_d    = 1'b0;
    case (state_q)
      ACUM: begin
        if (cancel) begin
          state_d = DEVOLUCION;
          rech_d  = ev_any;
        end else if (buy && hay) begin
          state_d = VENTA;
          rech_d  = ev_any;
        end else if (ev_any) begin
          // The whole event is accepted or the whole event is rejected.
          if (cabe) begin
            credito_d = sum_x[WIDTH-1:0];
          end else begin
            rech_d = 1'b1;
          end
        end
      end
      VENTA, DEVOLUCION: begin
        state_d   = ACUM;
        credito_d = '0;
        rech_d    = ev_any;
      end
      default: begin
        state_d   = ACUM;
        credito_d = '0;
      end
    endcase
  end

  // State, credit, coin history and rejection pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ACUM;
      credito_q <= '0;
      // All ones so a coin held through reset only counts after it re-rises.
      coin_q    <= 3'b111;
      rech_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      credito_q <= credito_d;
      coin_q    <= coin_in;
      rech_q    <= rech_d;
    end
  end

  // Moore output decode from state and credit.
  always_comb begin
    dispensa     = 1'b0;
    cambio_valid = 1'b0;
    cambio       = '0;
    case (state_q)
      VENTA: begin
        dispensa     = 1'b1;
        cambio_valid = 1'b1;
        cambio       = credito_q - PRICE_W;
      end
      DEVOLUCION: begin
        cambio_valid = 1'b1;
        cambio       = credito_q;
      end
      default: begin
        dispensa     = 1'b0;
        cambio_valid = 1'b0;
        cambio       = '0;
      end
    endcase
  end

  assign credito          = credito_q;
  assign hay_credito      = hay;
  assign moneda_rechazada = rech_q;

endmodule

// File: tb/tb_credito_acumulador.sv
// Bench for credito_acumulador at default parameters (WIDTH=5, PRICE=20,
// coins 1/5/10). Each record holds the inputs for one cycle and the outputs
// expected after the following rising edge.
module tb_credito_acumulador;

  localparam int PRICE = 20;

  logic       clk;
  logic       rst_n;
  logic [2:0] coin_in;
  logic       buy;
  logic       cancel;
  logic [4:0] credito;
  logic       hay_credito;
  logic       dispensa;
  logic [4:0] cambio;
  logic       cambio_valid;
  logic       moneda_rechazada;

  credito_acumulador dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .coin_in          (coin_in),
    .buy              (buy),
    .cancel           (cancel),
    .credito          (credito),
    .hay_credito      (hay_credito),
    .dispensa         (dispensa),
    .cambio           (cambio),
    .cambio_valid     (cambio_valid),
    .moneda_rechazada (moneda_rechazada)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [2:0] coin;
    logic       buy;
    logic       cancel;
    logic [4:0] cred;
    logic       disp;
    logic       cv;
    logic [4:0] camb;
    logic       rech;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   vec_idx = 0;

  function automatic vec_t mk(input logic r, input logic [2:0] c, input logic b,
                              input logic k, input int cr, input logic d,
                              input logic v, input int cb, input logic rj);
    vec_t x;
    x.rst_n = r;  x.coin = c;  x.buy = b;  x.cancel = k;
    x.cred  = 5'(cr); x.disp = d; x.cv = v; x.camb = 5'(cb); x.rech = rj;
    return x;
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %0d want %0d", name, idx, act, want);
    end
  endtask

  // Drive one record, queue its expectation, then compare after the edge.
  task automatic apply(input vec_t v);
    vec_t e;
    rst_n   = v.rst_n;
    coin_in = v.coin;
    buy     = v.buy;
    cancel  = v.cancel;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard vec %0d: got empty queue want entry", vec_idx);
    end else begin
      e = exp_q.pop_front();
      chk("credito",          vec_idx, int'(credito),          int'(e.cred));
      chk("hay_credito",      vec_idx, int'(hay_credito),      int'(e.cred) >= PRICE ? 1 : 0);
      chk("dispensa",         vec_idx, int'(dispensa),         int'(e.disp));
      chk("cambio_valid",     vec_idx, int'(cambio_valid),     int'(e.cv));
      chk("cambio",           vec_idx, int'(cambio),           int'(e.camb));
      chk("moneda_rechazada", vec_idx, int'(moneda_rechazada), int'(e.rech));
    end
    vec_idx++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; coin_in = 3'b000; buy = 1'b0; cancel = 1'b0;

    //                rst coin    buy cnc cred d  v  camb rech
    // reset, two 10-coins, 5-coin to 25, sale with change 5
    tbl.push_back(mk(0, 3'b000, 0, 0,  0, 0, 0,  0, 0));
    tbl.push_back(mk(0, 3'b000, 0, 0,  0, 0, 0,  0, 0));
    tbl.push_back(mk(1, 3'b000, 0, 0,  0, 0, 0,  0, 0));
    tbl.push_back(mk(1, 3'b100, 0, 0, 10, 0, 0,  0, 0));
    tbl.push_back(mk(1, 3'b000, 0, 0, 10, 0, 0,  0, 0));
    tbl.push_back(mk(1, 3'b100, 0, 0, 20, 0, 0,  0, 0));
    tbl.push_back(mk(1, 3'b000, 0, 0, 20, 0, 0,  0, 0));
    tbl.push_back(mk(1, 3'b010, 0, 0, 25, 0, 0,  0, 0));
    tbl.push_back(mk(1, 3'b000, 0, 0, 25, 0, 0,  0, 0));
    tbl.push_back(mk(1, 3'b000, 1, 0, 25, 1, 1,  5, 0));
    tbl.push_back(mk(1, 3'b000, 0, 0,  0, 0, 0,  0, 0));
    // credit 15, buy held without enough credit, coin during buy -> 20
    tbl.push_back(mk(1, 3'b100, 0, 0, 10, 0, 0,  0, 0));
    tbl.push_back(mk(1, 3'b000, 0, 0, 10, 0, 0,  0, 0));
    tbl.push_back(mk(1, 3'b010, 0, 0, 15, 0, 0,  0, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1, 3'b000, 1, 0, 15, 0, 0,  0, 0));
    tbl.push_back(mk(1, 3'b010, 1, 0, 20, 0, 0,  0, 0));
    tbl.push_back(mk(1, 3'b000, 0, 0, 20, 0, 0,  0, 0));
    // 30, overflowing 5-coin rejected, 1-coin fills to max 31
    tbl.push_back(mk(1, 3'b100, 0, 0, 30, 0, 0,  0, 0));
    tbl.push_back(mk(1, 3'b000, 0, 0, 30, 0, 0,  0, 0));
    tbl.push_back(mk(1, 3'b010, 0, 0, 30, 0, 0,  0, 1));
    tbl.push_back(mk(1, 3'b000, 0, 0, 30, 0, 0,  0, 0));
    tbl.push_back(mk(1, 3'b001, 0, 0, 31, 0, 0,  0, 0));
    tbl.push_back(mk(1, 3'b000, 0, 0, 31, 0, 0,  0, 0));
    // sale at 31 (change 11), coin during VENTA rejected
    tbl.push_back(mk(1, 3'b000, 1, 0, 31, 1, 1, 11, 0));
    tbl.push_back(mk(1, 3'b001, 0, 0,  0, 0, 0,  0, 1));
    // credit 12, then cancel+buy+coin together
    tbl.push_back(mk(1, 3'b100, 0, 0, 10, 0, 0,  0, 0));
    tbl.push_back(mk(1, 3'b000, 0, 0, 10, 0, 0,  0, 0));
    tbl.push_back(mk(1, 3'b001, 0, 0, 11, 0, 0,  0, 0));
    tbl.push_back(mk(1, 3'b000, 0, 0, 11, 0, 0,  0, 0));
    tbl.push_back(mk(1, 3'b001, 0, 0, 12, 0, 0,  0, 0));
    tbl.push_back(mk(1, 3'b000, 0, 0, 12, 0, 0,  0, 0));
    tbl.push_back(mk(1, 3'b001, 1, 1, 12, 0, 1, 12, 1));
    tbl.push_back(mk(1, 3'b000, 0, 0,  0, 0, 0,  0, 0));
    // simultaneous edges summed, cancel returns 16, cancel at zero
    tbl.push_back(mk(1, 3'b111, 0, 0, 16, 0, 0,  0, 0));
    tbl.push_back(mk(1, 3'b000, 0, 0, 16, 0, 0,  0, 0));
    tbl.push_back(mk(1, 3'b000, 0, 1, 16, 0, 1, 16, 0));
    tbl.push_back(mk(1, 3'b000, 0, 0,  0, 0, 0,  0, 0));
    tbl.push_back(mk(1, 3'b000, 0, 1,  0, 0, 1,  0, 0));
    tbl.push_back(mk(1, 3'b000, 0, 0,  0, 0, 0,  0, 0));
    // held buy at zero credit does nothing
    tbl.push_back(mk(1, 3'b000, 1, 0,  0, 0, 0,  0, 0));
    tbl.push_back(mk(1, 3'b000, 1, 0,  0, 0, 0,  0, 0));
    tbl.push_back(mk(1, 3'b000, 0, 0,  0, 0, 0,  0, 0));
    // exact price: change 0
    tbl.push_back(mk(1, 3'b100, 0, 0, 10, 0, 0,  0, 0));
    tbl.push_back(mk(1, 3'b000, 0, 0, 10, 0, 0,  0, 0));
    tbl.push_back(mk(1, 3'b100, 0, 0, 20, 0, 0,  0, 0));
    tbl.push_back(mk(1, 3'b000, 1, 0, 20, 1, 1,  0, 0));
    tbl.push_back(mk(1, 3'b000, 0, 0,  0, 0, 0,  0, 0));
    // buy wins over a coin in the same cycle; the coin is rejected
    tbl.push_back(mk(1, 3'b100, 0, 0, 10, 0, 0,  0, 0));
    tbl.push_back(mk(1, 3'b000, 0, 0, 10, 0, 0,  0, 0));
    tbl.push_back(mk(1, 3'b100, 0, 0, 20, 0, 0,  0, 0));
    tbl.push_back(mk(1, 3'b001, 1, 0, 20, 1, 1,  0, 1));
    tbl.push_back(mk(1, 3'b000, 0, 0,  0, 0, 0,  0, 0));

    foreach (tbl[i]) apply(tbl[i]);

    // Coin held high across reset is not counted until it re-rises.
    apply(mk(0, 3'b100, 0, 0,  0, 0, 0, 0, 0));
    apply(mk(0, 3'b100, 0, 0,  0, 0, 0, 0, 0));
    apply(mk(1, 3'b100, 0, 0,  0, 0, 0, 0, 0));
    apply(mk(1, 3'b100, 0, 0,  0, 0, 0, 0, 0));
    apply(mk(1, 3'b000, 0, 0,  0, 0, 0, 0, 0));
    apply(mk(1, 3'b100, 0, 0, 10, 0, 0, 0, 0));
    apply(mk(1, 3'b000, 0, 0, 10, 0, 0, 0, 0));
    apply(mk(1, 3'b100, 0, 0, 20, 0, 0, 0, 0));
    apply(mk(1, 3'b000, 0, 0, 20, 0, 0, 0, 0));
    // Reset in the cycle buy is sampled: no sale, credit cleared.
    apply(mk(0, 3'b000, 1, 0,  0, 0, 0, 0, 0));
    apply(mk(1, 3'b000, 0, 0,  0, 0, 0, 0, 0));
    apply(mk(1, 3'b100, 0, 0, 10, 0, 0, 0, 0));
    apply(mk(1, 3'b000, 0, 0, 10, 0, 0, 0, 0));
    apply(mk(1, 3'b100, 0, 0, 20, 0, 0, 0, 0));
    apply(mk(1, 3'b000, 0, 0, 20, 0, 0, 0, 0));
    // Reset during the VENTA cycle: nothing dispensed afterwards.
    apply(mk(1, 3'b000, 1, 0, 20, 1, 1, 0, 0));
    apply(mk(0, 3'b000, 1, 0,  0, 0, 0, 0, 0));
    apply(mk(1, 3'b000, 0, 0,  0, 0, 0, 0, 0));
    apply(mk(1, 3'b000, 0, 0,  0, 0, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
